// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly: x = (a + b*w)/2, y = (a - b*w)/2, three-stage pipeline
// with per-stage butterfly indexing and a completion pulse on the last output.
module fft_butterfly #(
    parameter int DW = 8,
    parameter int TW = 8,
    parameter int N  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start,
    input  logic [2:0]                 i_stage,
    input  logic                       i_dv,
    input  logic [2*TW-1:0]            i_twiddle,
    input  logic [2*DW-1:0]            i_a,
    input  logic [2*DW-1:0]            i_b,
    output logic [2*DW-1:0]            o_x,
    output logic [2*DW-1:0]            o_y,
    output logic                       o_dv,
    output logic                       o_we,
    output logic [$clog2(N/2)-1:0]     o_idx,
    output logic [2:0]                 o_stage,
    output logic                       o_done
);
    localparam int IW = $clog2(N/2);
    localparam int PW = DW + TW;
    localparam int SW = PW + 1;
    localparam int AW = DW + 3;
    localparam logic signed [SW-1:0]   RND     = SW'(2 ** (TW - 3));
    localparam logic signed [AW-2:0]   SAT_MAX = (AW-1)'(2 ** (DW - 1) - 1);
    localparam logic signed [AW-2:0]   SAT_MIN = (AW-1)'(-(2 ** (DW - 1)));
    localparam logic [IW-1:0]          LAST_IDX = IW'(N / 2 - 1);

    logic                 s1_v_q, s2_v_q, s3_v_q, dv_q, done_q;
    logic [2*DW-1:0]      s1_a_q, s1_b_q, s2_a_q, s3_a_q, x_q, y_q;
    logic [2*TW-1:0]      s1_w_q;
    logic [IW-1:0]        s1_idx_q, s2_idx_q, s3_idx_q, idx_q, cnt_q, cnt_d, idx_in;
    logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    logic signed [PW-1:0] p_rr_d, p_ii_d, p_ri_d, p_ir_d;
    logic signed [DW+1:0] t_re_q, t_im_q, t_re_d, t_im_d;
    logic [2:0]           stage_q;
    logic [2*DW-1:0]      x_d, y_d;
    logic                 done_d;

    logic signed [DW-1:0] b_re, b_im, a_re, a_im;
    logic signed [TW-1:0] w_re, w_im;
    logic signed [SW-1:0] sum_re, sum_im;
    logic signed [AW-1:0] s_re, s_im, d_re, d_im;

    function automatic logic [DW-1:0] sat(input logic signed [AW-2:0] v);
        if (v > SAT_MAX)      return SAT_MAX[DW-1:0];
        else if (v < SAT_MIN) return SAT_MIN[DW-1:0];
        else                  return v[DW-1:0];
    endfunction

    // An i_start cycle's own operands are index 0; older in-flight data is dropped.
    assign idx_in = i_start ? '0 : cnt_q;
    assign cnt_d  = i_dv ? idx_in + IW'(1) : idx_in;

    assign b_re   = $signed(s1_b_q[2*DW-1:DW]);
    assign b_im   = $signed(s1_b_q[DW-1:0]);
    assign w_re   = $signed(s1_w_q[2*TW-1:TW]);
    assign w_im   = $signed(s1_w_q[TW-1:0]);
    assign p_rr_d = PW'(b_re) * PW'(w_re);
    assign p_ii_d = PW'(b_im) * PW'(w_im);
    assign p_ri_d = PW'(b_re) * PW'(w_im);
    assign p_ir_d = PW'(b_im) * PW'(w_re);

    // Round half up, then the arithmetic shift is just a bit-field select.
    assign sum_re = SW'(p_rr_q) - SW'(p_ii_q) + RND;
    assign sum_im = SW'(p_ri_q) + SW'(p_ir_q) + RND;
    assign t_re_d = sum_re[TW-2 +: DW+2];
    assign t_im_d = sum_im[TW-2 +: DW+2];

    assign a_re   = $signed(s3_a_q[2*DW-1:DW]);
    assign a_im   = $signed(s3_a_q[DW-1:0]);
    assign s_re   = AW'(a_re) + AW'(t_re_q);
    assign s_im   = AW'(a_im) + AW'(t_im_q);
    assign d_re   = AW'(a_re) - AW'(t_re_q);
    assign d_im   = AW'(a_im) - AW'(t_im_q);
    assign x_d    = {sat(s_re[AW-1:1]), sat(s_im[AW-1:1])};
    assign y_d    = {sat(d_re[AW-1:1]), sat(d_im[AW-1:1])};
    assign done_d = s3_v_q && (s3_idx_q == LAST_IDX);

    logic unused_bits;
    assign unused_bits = ^{sum_re[SW-1], sum_re[TW-3:0], sum_im[SW-1], sum_im[TW-3:0],
                           s_re[0], s_im[0], d_re[0], d_im[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q <= 1'b0; s2_v_q <= 1'b0; s3_v_q <= 1'b0;
            dv_q   <= 1'b0; done_q <= 1'b0;
            s1_a_q <= '0; s1_b_q <= '0; s1_w_q <= '0; s1_idx_q <= '0;
            p_rr_q <= '0; p_ii_q <= '0; p_ri_q <= '0; p_ir_q <= '0;
            s2_a_q <= '0; s2_idx_q <= '0;
            t_re_q <= '0; t_im_q <= '0; s3_a_q <= '0; s3_idx_q <= '0;
            x_q    <= '0; y_q <= '0; idx_q <= '0;
            cnt_q  <= '0; stage_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            s1_v_q <= i_dv;
            if (i_dv) begin
                s1_a_q   <= i_a;
                s1_b_q   <= i_b;
                s1_w_q   <= i_twiddle;
                s1_idx_q <= idx_in;
            end
            s2_v_q   <= s1_v_q & ~i_start;
            p_rr_q   <= p_rr_d;
            p_ii_q   <= p_ii_d;
            p_ri_q   <= p_ri_d;
            p_ir_q   <= p_ir_d;
            s2_a_q   <= s1_a_q;
            s2_idx_q <= s1_idx_q;
            s3_v_q   <= s2_v_q & ~i_start;
            t_re_q   <= t_re_d;
            t_im_q   <= t_im_d;
            s3_a_q   <= s2_a_q;
            s3_idx_q <= s2_idx_q;
            dv_q     <= s3_v_q & ~i_start;
            done_q   <= done_d & ~i_start;
            if (s3_v_q && !i_start) begin
                x_q   <= x_d;
                y_q   <= y_d;
                idx_q <= s3_idx_q;
            end
            if (i_start) stage_q <= i_stage;
        end
    end

    assign o_x     = x_q;
    assign o_y     = y_q;
    assign o_dv    = dv_q;
    assign o_we    = dv_q;
    assign o_idx   = idx_q;
    assign o_stage = stage_q;
    assign o_done  = done_q;
endmodule
